// File: rtl/gene_net_analyzer_pkg.sv
// Shared constants, types and the gene-network next-state function.
package gene_net_pkg;

  localparam int unsigned STATE_W    = 8;
  localparam int unsigned NUM_STATES = 1 << STATE_W;

  typedef logic [STATE_W-1:0] state_t;

  // All eight genes update simultaneously from the current state.
  function automatic state_t gene_next(input state_t x);
    state_t n;
    n[7] = x[5] & x[3];
    n[6] = x[4] | x[7];
    n[5] = x[2] & ~x[0];
    n[4] = x[6];
    n[3] = x[7] ^ x[2];
    n[2] = x[3] & x[5];
    n[1] = x[0];
    n[0] = x[1];
    return n;
  endfunction

endpackage

// File: rtl/gene_net_analyzer_if.sv
// Bus between the analyzer and whoever supplies the initial state and
// watches the trajectory.
interface gene_net_analyzer_if;
  import gene_net_pkg::*;

  state_t init_val_chk;
  state_t x_out;
  logic   fixed_flag;
  logic   cycle_flag;

  modport master (
    output init_val_chk,
    input  x_out,
    input  fixed_flag,
    input  cycle_flag
  );

  modport slave (
    input  init_val_chk,
    output x_out,
    output fixed_flag,
    output cycle_flag
  );

endinterface

// File: rtl/gene_net_analyzer_step.sv
// Combinational next-state logic of the gene network.
module gene_net_step
  import gene_net_pkg::*;
(
  input  state_t x_in,
  output state_t x_next
);

  assign x_next = gene_next(x_in);

endmodule

// File: rtl/gene_net_analyzer.sv
// Iterates the gene network from a loaded initial state and flags whether
// the trajectory settles on a fixed point or falls into a limit cycle.
module gene_net_analyzer
  import gene_net_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  gene_net_analyzer_if.slave    bus
);

  state_t                  x;
  state_t                  x_nxt;
  state_t                  init_q;
  logic [NUM_STATES-1:0]   visited;
  logic                    load_pending;
  logic                    fixed_q;
  logic                    cycle_q;
  logic                    load;

  gene_net_step u_step (
    .x_in   (x),
    .x_next (x_nxt)
  );

  // A new initial value, or the first edge after reset, restarts the run.
  always_comb begin
    load = load_pending | (bus.init_val_chk != init_q);
  end

  // State register, visited bitmap and sticky flags; a load overrides any
  // flag update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= '0;
      init_q       <= '0;
      visited      <= '0;
      fixed_q      <= 1'b0;
      cycle_q      <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      init_q <= bus.init_val_chk;
      if (load) begin
        x            <= bus.init_val_chk;
        visited      <= '0;
        fixed_q      <= 1'b0;
        cycle_q      <= 1'b0;
        load_pending <= 1'b0;
      end else begin
        x          <= x_nxt;
        visited[x] <= 1'b1;
        fixed_q    <= fixed_q | (x_nxt == x);
        cycle_q    <= cycle_q | (visited[x] & (x_nxt != x));
      end
    end
  end

  assign bus.x_out      = x;
  assign bus.fixed_flag = fixed_q;
  assign bus.cycle_flag = cycle_q;

endmodule

// File: tb/tb_gene_net_analyzer.sv
// Directed bench for gene_net_analyzer with hand-computed trajectories.
module tb_gene_net_analyzer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gene_net_analyzer_if bus ();

  gene_net_analyzer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ex, input logic ef, input logic ec);
    chk({tag, ".x"}, bus.x_out, ex);
    chk({tag, ".fixed"}, {7'd0, bus.fixed_flag}, {7'd0, ef});
    chk({tag, ".cycle"}, {7'd0, bus.cycle_flag}, {7'd0, ec});
  endtask

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [7:0] ex, input logic ef, input logic ec);
    tick();
    chk_all(tag, ex, ef, ec);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.init_val_chk = 8'h00;

    // Reset state
    #12;
    chk_all("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Zero fixed point: first edge loads 00, fixed one edge later
    step_chk("zero.e0", 8'h00, 1'b0, 1'b0);
    step_chk("zero.e1", 8'h00, 1'b1, 1'b0);
    step_chk("zero.e2", 8'h00, 1'b1, 1'b0);

    // Transient then fixed point 53
    bus.init_val_chk = 8'hFF;
    step_chk("ff.e0", 8'hFF, 1'b0, 1'b0);
    step_chk("ff.e1", 8'hD7, 1'b0, 1'b0);
    step_chk("ff.e2", 8'h53, 1'b0, 1'b0);
    step_chk("ff.e3", 8'h53, 1'b1, 1'b0);
    step_chk("ff.e4", 8'h53, 1'b1, 1'b0);

    // Two-cycle 02 <-> 01
    bus.init_val_chk = 8'h02;
    step_chk("two.e0", 8'h02, 1'b0, 1'b0);
    step_chk("two.e1", 8'h01, 1'b0, 1'b0);
    step_chk("two.e2", 8'h02, 1'b0, 1'b0);
    step_chk("two.e3", 8'h01, 1'b0, 1'b1);
    step_chk("two.e4", 8'h02, 1'b0, 1'b1);

    // Transient then cycle 10 <-> 40; load clears the earlier cycle flag
    bus.init_val_chk = 8'h24;
    step_chk("tc.e0", 8'h24, 1'b0, 1'b0);
    step_chk("tc.e1", 8'h28, 1'b0, 1'b0);
    step_chk("tc.e2", 8'h84, 1'b0, 1'b0);
    step_chk("tc.e3", 8'h60, 1'b0, 1'b0);
    step_chk("tc.e4", 8'h10, 1'b0, 1'b0);
    step_chk("tc.e5", 8'h40, 1'b0, 1'b0);
    step_chk("tc.e6", 8'h10, 1'b0, 1'b0);
    step_chk("tc.e7", 8'h40, 1'b0, 1'b1);

    // Rewriting the same value must not restart
    bus.init_val_chk = 8'h24;
    step_chk("same.e8", 8'h10, 1'b0, 1'b1);
    step_chk("same.e9", 8'h40, 1'b0, 1'b1);

    // Restart during the 24 transient with 38
    bus.init_val_chk = 8'hFF;
    step_chk("rs.ff", 8'hFF, 1'b0, 1'b0);
    bus.init_val_chk = 8'h24;
    step_chk("rs.24", 8'h24, 1'b0, 1'b0);
    step_chk("rs.28", 8'h28, 1'b0, 1'b0);
    bus.init_val_chk = 8'h38;
    step_chk("rs.e0", 8'h38, 1'b0, 1'b0);
    step_chk("rs.e1", 8'hC4, 1'b0, 1'b0);
    step_chk("rs.e2", 8'h70, 1'b0, 1'b0);
    step_chk("rs.e3", 8'h50, 1'b0, 1'b0);
    step_chk("rs.e4", 8'h50, 1'b1, 1'b0);

    // Asynchronous reset mid-run, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("areset", 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step_chk("ar.e0", 8'h38, 1'b0, 1'b0);
    step_chk("ar.e1", 8'hC4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
